// File: rtl/clock_distribution_ctrl.sv
// clock_distribution_ctrl
// Power-up sequencer and analog-test-bus (ATB) controller for the IDAC clock
// distribution block. It raises pdb only after the bias reference has settled,
// reports ready once the block has had time to settle, and lets a test master
// either select a static ATB mode or run a timed scan through modes 01/10/11.
// Loss of supply (or of the bias reference once active) forces a safe
// power-down into a sticky FAULT state.
//
// Ports:
//   clk            controller clock
//   rst            synchronous active-high reset
//   en             level-sensitive enable request
//   supply_ok      supply within limits (already synchronised)
//   iref_ok        bias reference within limits (already synchronised)
//   atb_req_valid  static ATB request valid
//   atb_req_mode   requested atb_ena value
//   atb_req_ready  static request can be accepted (combinational)
//   atb_scan_start single-cycle pulse, start an ATB scan
//   pdb            power-down-bar to the clock distribution block
//   atb_ena        ATB select to the clock distribution block
//   ready          block powered and settled
//   busy           sequencing or scanning in progress (combinational)
//   fault          sticky fault indicator
//   atb_sample     one-cycle pulse in the last dwell cycle of each scan step
module clock_distribution_ctrl #(
  parameter int unsigned BIAS_WAIT_CYC  = 16,
  parameter int unsigned PDB_SETTLE_CYC = 8,
  parameter int unsigned ATB_DWELL_CYC  = 32,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       supply_ok,
  input  logic       iref_ok,
  input  logic       atb_req_valid,
  input  logic [1:0] atb_req_mode,
  output logic       atb_req_ready,
  input  logic       atb_scan_start,
  output logic       pdb,
  output logic [1:0] atb_ena,
  output logic       ready,
  output logic       busy,
  output logic       fault,
  output logic       atb_sample
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StBias   = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StScan   = 3'd4;
  localparam logic [2:0] StFault  = 3'd5;

  // Loads are N-1 so a count of N cycles ends on the edge that sees zero.
  localparam logic [CNT_W-1:0] BiasLoad   = CNT_W'(BIAS_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(PDB_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DwellLoad  = CNT_W'(ATB_DWELL_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pdb_q, pdb_d;
  logic [1:0]       atb_ena_q, atb_ena_d;
  logic [1:0]       saved_mode_q, saved_mode_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             atb_sample_q, atb_sample_d;

  logic run_state;
  logic on_state;
  logic fault_cond;
  logic cnt_zero;

  // States in which the block is (being) powered and en/supply are watched.
  assign run_state = (state_q == StBias) || (state_q == StSettle) ||
                     (state_q == StActive) || (state_q == StScan);
  // States in which the reference must stay good.
  assign on_state  = (state_q == StActive) || (state_q == StScan);
  assign fault_cond = (run_state && !supply_ok) || (on_state && !iref_ok);
  assign cnt_zero   = (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    pdb_d        = pdb_q;
    atb_ena_d    = atb_ena_q;
    saved_mode_d = saved_mode_q;
    ready_d      = ready_q;
    fault_d      = fault_q;

    if (fault_cond) begin
      // Fault wins over a simultaneous en drop.
      state_d   = StFault;
      pdb_d     = 1'b0;
      atb_ena_d = 2'b00;
      ready_d   = 1'b0;
      fault_d   = 1'b1;
    end else if (run_state && !en) begin
      state_d      = StIdle;
      pdb_d        = 1'b0;
      atb_ena_d    = 2'b00;
      ready_d      = 1'b0;
      saved_mode_d = 2'b00;
    end else begin
      case (state_q)
        StIdle: begin
          if (en && supply_ok) begin
            state_d = StBias;
            cnt_d   = BiasLoad;
          end
        end
        StBias: begin
          // No timeout: a missing reference parks the sequencer here.
          if (cnt_zero && iref_ok) begin
            state_d = StSettle;
            pdb_d   = 1'b1;
            cnt_d   = SettleLoad;
          end
        end
        StSettle: begin
          if (cnt_zero) begin
            state_d = StActive;
            ready_d = 1'b1;
          end
        end
        StActive: begin
          // Scan start outranks a static request, which stays pending.
          if (atb_scan_start) begin
            state_d   = StScan;
            atb_ena_d = 2'b01;
            cnt_d     = DwellLoad;
          end else if (atb_req_valid) begin
            atb_ena_d    = atb_req_mode;
            saved_mode_d = atb_req_mode;
          end
        end
        StScan: begin
          // The current step is encoded by atb_ena itself.
          if (cnt_zero) begin
            if (atb_ena_q == 2'b11) begin
              state_d   = StActive;
              atb_ena_d = saved_mode_q;
            end else begin
              atb_ena_d = atb_ena_q + 2'b01;
              cnt_d     = DwellLoad;
            end
          end
        end
        StFault: begin
          if (!en) begin
            state_d      = StIdle;
            fault_d      = 1'b0;
            saved_mode_d = 2'b00;
          end
        end
        default: begin
          state_d      = StIdle;
          cnt_d        = '0;
          pdb_d        = 1'b0;
          atb_ena_d    = 2'b00;
          saved_mode_d = 2'b00;
          ready_d      = 1'b0;
          fault_d      = 1'b0;
        end
      endcase
    end

    // High in the cycle where a scan step sits at its final count.
    atb_sample_d = (state_d == StScan) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pdb_q        <= 1'b0;
      atb_ena_q    <= 2'b00;
      saved_mode_q <= 2'b00;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      atb_sample_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pdb_q        <= pdb_d;
      atb_ena_q    <= atb_ena_d;
      saved_mode_q <= saved_mode_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      atb_sample_q <= atb_sample_d;
    end
  end

  assign pdb           = pdb_q;
  assign atb_ena       = atb_ena_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign atb_sample    = atb_sample_q;
  assign busy          = (state_q == StBias) || (state_q == StSettle) || (state_q == StScan);
  assign atb_req_ready = (state_q == StActive) && !atb_scan_start;

endmodule

// File: tb/tb_clock_distribution_ctrl.sv
// Self-checking bench for clock_distribution_ctrl with default parameters.
// Output vectors are packed as {pdb, atb_ena[1:0], ready, busy, fault, atb_sample, atb_req_ready}.
module tb_clock_distribution_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       supply_ok;
  logic       iref_ok;
  logic       atb_req_valid;
  logic [1:0] atb_req_mode;
  logic       atb_req_ready;
  logic       atb_scan_start;
  logic       pdb;
  logic [1:0] atb_ena;
  logic       ready;
  logic       busy;
  logic       fault;
  logic       atb_sample;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_distribution_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .supply_ok      (supply_ok),
    .iref_ok        (iref_ok),
    .atb_req_valid  (atb_req_valid),
    .atb_req_mode   (atb_req_mode),
    .atb_req_ready  (atb_req_ready),
    .atb_scan_start (atb_scan_start),
    .pdb            (pdb),
    .atb_ena        (atb_ena),
    .ready          (ready),
    .busy           (busy),
    .fault          (fault),
    .atb_sample     (atb_sample)
  );

  typedef struct {
    int         ncyc;
    logic       en;
    logic       sup;
    logic       iref;
    logic       valid;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [7:0] mk(input logic p, input logic [1:0] a, input logic r,
                                    input logic b, input logic f, input logic s,
                                    input logic rr);
    return {p, a, r, b, f, s, rr};
  endfunction

  function automatic vec_t mkv(input int n, input logic e, input logic su, input logic ir,
                               input logic v, input logic [1:0] m, input logic [7:0] x);
    vec_t t;
    t.ncyc = n; t.en = e; t.sup = su; t.iref = ir; t.valid = v; t.mode = m; t.exp = x;
    return t;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {pdb, atb_ena, ready, busy, fault, atb_sample, atb_req_ready};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: {pdb,atb,rdy,busy,flt,smp,rr} got %b required %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic su, input logic ir, input logic v,
                       input logic [1:0] m, input logic sc);
    en = e; supply_ok = su; iref_ok = ir; atb_req_valid = v; atb_req_mode = m;
    atb_scan_start = sc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick(2);
    chk("reset", 8'b0);
    rst = 1'b0;
  endtask

  // Edges 0..24 with everything good: lands in ACTIVE with ready high.
  task automatic bring_up();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    tick(25);
    chk("bring_up", mk(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Checks scan cycles 1..upto; a stray scan_start at cycle 10 must be ignored.
  task automatic scan_cycles(input int upto, input string tag, output int nsamp);
    logic [1:0] a;
    nsamp = 0;
    for (int k = 1; k <= upto; k++) begin
      a = (k <= 32) ? 2'b01 : (k <= 64) ? 2'b10 : 2'b11;
      chk($sformatf("%s_k%0d", tag, k),
          mk(1'b1, a, 1'b1, 1'b1, 1'b0, ((k % 32) == 0), 1'b0));
      nsamp += int'(atb_sample);
      atb_scan_start = (k == 10);
      if (k < upto) tick(1);
    end
    atb_scan_start = 1'b0;
  endtask

  initial begin
    int ns;
    int nbad;

    vecs[0]  = mkv(1,  1, 1, 1, 0, 2'b00, mk(0, 2'b00, 0, 1, 0, 0, 0));
    vecs[1]  = mkv(15, 1, 1, 1, 0, 2'b00, mk(0, 2'b00, 0, 1, 0, 0, 0));
    vecs[2]  = mkv(1,  1, 1, 1, 0, 2'b00, mk(1, 2'b00, 0, 1, 0, 0, 0));
    vecs[3]  = mkv(7,  1, 1, 1, 0, 2'b00, mk(1, 2'b00, 0, 1, 0, 0, 0));
    vecs[4]  = mkv(1,  1, 1, 1, 0, 2'b00, mk(1, 2'b00, 1, 0, 0, 0, 1));
    vecs[5]  = mkv(1,  1, 1, 1, 1, 2'b11, mk(1, 2'b11, 1, 0, 0, 0, 1));
    vecs[6]  = mkv(3,  1, 1, 1, 0, 2'b01, mk(1, 2'b11, 1, 0, 0, 0, 1));
    vecs[7]  = mkv(1,  1, 1, 1, 1, 2'b01, mk(1, 2'b01, 1, 0, 0, 0, 1));
    vecs[8]  = mkv(1,  1, 1, 1, 1, 2'b11, mk(1, 2'b11, 1, 0, 0, 0, 1));
    vecs[9]  = mkv(1,  0, 1, 1, 0, 2'b00, mk(0, 2'b00, 0, 0, 0, 0, 0));
    vecs[10] = mkv(2,  0, 0, 1, 0, 2'b00, mk(0, 2'b00, 0, 0, 0, 0, 0));
    vecs[11] = mkv(3,  1, 0, 1, 0, 2'b00, mk(0, 2'b00, 0, 0, 0, 0, 0));
    vecs[12] = mkv(1,  1, 1, 1, 0, 2'b00, mk(0, 2'b00, 0, 1, 0, 0, 0));
    vecs[13] = mkv(1,  1, 0, 1, 0, 2'b00, mk(0, 2'b00, 0, 0, 1, 0, 0));
    vecs[14] = mkv(2,  1, 1, 1, 0, 2'b00, mk(0, 2'b00, 0, 0, 1, 0, 0));
    vecs[15] = mkv(1,  0, 1, 1, 0, 2'b00, mk(0, 2'b00, 0, 0, 0, 0, 0));

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].sup, vecs[i].iref, vecs[i].valid, vecs[i].mode, 1'b0);
      tick(vecs[i].ncyc);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reference late: iref low through edge 40, pdb at 41, ready at 49.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick(41);
    chk("iref_wait", mk(0, 2'b00, 0, 1, 0, 0, 0));
    iref_ok = 1'b1;
    tick(1);
    chk("iref_pdb", mk(1, 2'b00, 0, 1, 0, 0, 0));
    tick(7);
    chk("iref_settle", mk(1, 2'b00, 0, 1, 0, 0, 0));
    tick(1);
    chk("iref_ready", mk(1, 2'b00, 1, 0, 0, 0, 1));

    // Static request then a full scan returning to the saved mode.
    atb_req_valid = 1'b1; atb_req_mode = 2'b11;
    tick(1);
    chk("static_11", mk(1, 2'b11, 1, 0, 0, 0, 1));
    atb_req_valid = 1'b0;
    atb_scan_start = 1'b1;
    tick(1);
    atb_scan_start = 1'b0;
    scan_cycles(96, "scan", ns);
    chk_int("scan_samples", ns, 3);
    tick(1);
    chk("scan_end", mk(1, 2'b11, 1, 0, 0, 0, 1));

    // Scan start and request together: request waits for the scan to finish.
    atb_req_valid = 1'b1; atb_req_mode = 2'b10; atb_scan_start = 1'b1;
    #1;
    chk("both_pre", mk(1, 2'b11, 1, 0, 0, 0, 0));
    tick(1);
    atb_scan_start = 1'b0;
    scan_cycles(96, "scan2", ns);
    chk_int("scan2_samples", ns, 3);
    tick(1);
    chk("scan2_end", mk(1, 2'b11, 1, 0, 0, 0, 1));
    tick(1);
    chk("pending_accept", mk(1, 2'b10, 1, 0, 0, 0, 1));
    atb_req_valid = 1'b0;

    // Supply loss mid-scan, sticky fault, cleared by en low.
    atb_scan_start = 1'b1;
    tick(1);
    atb_scan_start = 1'b0;
    scan_cycles(40, "scan3", ns);
    supply_ok = 1'b0;
    tick(1);
    chk("supply_drop", mk(0, 2'b00, 0, 0, 1, 0, 0));
    supply_ok = 1'b1;
    tick(3);
    chk("fault_sticky", mk(0, 2'b00, 0, 0, 1, 0, 0));
    en = 1'b0;
    tick(1);
    chk("fault_clear", 8'b0);

    // en low and supply loss on the same edge: fault wins.
    do_reset();
    bring_up();
    en = 1'b0; supply_ok = 1'b0;
    tick(1);
    chk("prio_fault", mk(0, 2'b00, 0, 0, 1, 0, 0));
    supply_ok = 1'b1;
    tick(1);
    chk("prio_clear", 8'b0);

    // Reference loss while active.
    bring_up();
    iref_ok = 1'b0;
    tick(1);
    chk("iref_loss", mk(0, 2'b00, 0, 0, 1, 0, 0));
    en = 1'b0; iref_ok = 1'b1;
    tick(1);
    chk("iref_loss_clear", 8'b0);

    // en dropped during SETTLE.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    tick(20);
    chk("settle_mid", mk(1, 2'b00, 0, 1, 0, 0, 0));
    en = 1'b0;
    tick(1);
    chk("settle_abort", 8'b0);
    tick(10);
    chk("settle_abort_hold", 8'b0);

    // Reset during a scan: everything back to reset values, no late pulses.
    do_reset();
    bring_up();
    atb_scan_start = 1'b1;
    tick(1);
    atb_scan_start = 1'b0;
    tick(20);
    rst = 1'b1; en = 1'b0;
    tick(1);
    chk("rst_scan", 8'b0);
    rst = 1'b0;
    nbad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if ({pdb, atb_ena, ready, atb_sample} !== 5'b0) nbad++;
    end
    chk_int("rst_scan_quiet", nbad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
